// File: rtl/fc_tx_scheduler.sv
// FC_Port transmit word scheduler: primitive sequences, Idle fill, frame words.
// Latency: the word choice follows rx_state one cycle late; frame_ready is same-cycle.
// Backpressure: frame words are held off by the entry Idles, the inter-frame gap and non-Active states.

package fc;
    typedef enum logic [3:0] {
        ST_AC  = 4'd0,
        ST_LR1 = 4'd1,
        ST_LR2 = 4'd2,
        ST_LR3 = 4'd3,
        ST_LF1 = 4'd4,
        ST_LF2 = 4'd5,
        ST_OL1 = 4'd6,
        ST_OL2 = 4'd7,
        ST_OL3 = 4'd8
    } state_t;
endpackage

module fc_tx_scheduler #(
    parameter int ENTRY_IDLES = 6,
    parameter int IFG_IDLES   = 6,
    parameter int SEQ_MIN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rx_state,
    input  logic       frame_valid,
    input  logic       frame_last,
    output logic       frame_ready,
    output logic       frame_abort,
    output logic [2:0] tx_sel,
    output logic       tx_active
);

    localparam logic [2:0] W_IDLE  = 3'd0;
    localparam logic [2:0] W_OLS   = 3'd1;
    localparam logic [2:0] W_NOS   = 3'd2;
    localparam logic [2:0] W_LR    = 3'd3;
    localparam logic [2:0] W_LRR   = 3'd4;
    localparam logic [2:0] W_FRAME = 3'd5;

    localparam int MAX_AB = (ENTRY_IDLES > IFG_IDLES) ? ENTRY_IDLES : IFG_IDLES;
    localparam int MAXV   = (MAX_AB > SEQ_MIN) ? MAX_AB : SEQ_MIN;
    localparam int CW     = (MAXV < 2) ? 1 : $clog2(MAXV + 1);

    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_IDLES);
    localparam logic [CW-1:0] IFG_LD   = CW'(IFG_IDLES);
    localparam logic [CW-1:0] SEQ_LIM  = CW'(SEQ_MIN);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [3:0]    st_q, st_d;
    logic [2:0]    last_q, last_d;
    logic [CW-1:0] seq_q, seq_d;
    logic [CW-1:0] entry_q, entry_d;
    logic [CW-1:0] gap_q, gap_d;
    logic          in_frame_q, in_frame_d;
    logic          abort_q, abort_d;
    logic          active_q, active_d;

    logic [2:0]    target;
    logic [2:0]    word;
    logic          hold;
    logic          in_next;

    function automatic logic is_prim(input logic [2:0] w);
        return (w == W_OLS) || (w == W_NOS) || (w == W_LR) || (w == W_LRR);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q       <= fc::ST_LF2;
            last_q     <= W_NOS;
            seq_q      <= '0;
            entry_q    <= ENTRY_LD;
            gap_q      <= '0;
            in_frame_q <= 1'b0;
            abort_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            last_q     <= last_d;
            seq_q      <= seq_d;
            entry_q    <= entry_d;
            gap_q      <= gap_d;
            in_frame_q <= in_frame_d;
            abort_q    <= abort_d;
            active_q   <= active_d;
        end
    end

    // Output decode from registered state plus the upstream valid
    always_comb begin
        target = W_NOS;
        case (st_q)
            fc::ST_AC:  target = W_IDLE;
            fc::ST_LF1: target = W_OLS;
            fc::ST_LF2: target = W_NOS;
            fc::ST_OL1: target = W_OLS;
            fc::ST_OL2: target = W_LR;
            fc::ST_OL3: target = W_NOS;
            fc::ST_LR1: target = W_LR;
            fc::ST_LR2: target = W_LRR;
            fc::ST_LR3: target = W_IDLE;
            default:    target = W_NOS;
        endcase

        // A running primitive must reach SEQ_MIN words before another primitive replaces it;
        // Idle and frame words never hold a switch back.
        hold = is_prim(last_q) && (target != W_IDLE) && (target != last_q) && (seq_q < SEQ_LIM);

        frame_ready = frame_valid & active_q & ((gap_q == '0) | in_frame_q);
        if (frame_ready) begin
            word = W_FRAME;
        end else if (hold) begin
            word = last_q;
        end else begin
            word = target;
        end

        tx_sel      = word;
        frame_abort = abort_q;
        tx_active   = active_q;
    end

    // Next-state
    always_comb begin
        st_d   = rx_state;
        last_d = word;

        seq_d = '0;
        if (is_prim(word)) begin
            if (word == last_q) begin
                seq_d = (seq_q == SEQ_LIM) ? seq_q : seq_q + ONE;
            end else begin
                seq_d = ONE;
            end
        end

        in_next    = frame_ready ? ~frame_last : in_frame_q;
        // An accepted last word closes the frame cleanly even if rx_state leaves AC now.
        abort_d    = in_next & (rx_state != fc::ST_AC);
        in_frame_d = in_next & ~abort_d;

        gap_d = gap_q;
        if (abort_d) begin
            gap_d = '0;
        end else if (frame_ready && frame_last) begin
            gap_d = IFG_LD;
        end else if ((word == W_IDLE) && (gap_q != '0)) begin
            gap_d = gap_q - ONE;
        end

        entry_d = entry_q;
        if ((rx_state == fc::ST_AC) && (st_q != fc::ST_AC)) begin
            entry_d = ENTRY_LD;
        end else if ((word == W_IDLE) && (entry_q != '0)) begin
            entry_d = entry_q - ONE;
        end

        active_d = (rx_state == fc::ST_AC) && (entry_d == '0);
    end

endmodule

// File: tb/tb_fc_tx_scheduler.sv
// Directed and randomized checks of fc_tx_scheduler against a history-based reference model.
module tb_fc_tx_scheduler;

    localparam int ENTRY = 6;
    localparam int IFG   = 6;
    localparam int SEQ   = 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] OLS   = 3'd1;
    localparam logic [2:0] NOS   = 3'd2;
    localparam logic [2:0] LR    = 3'd3;
    localparam logic [2:0] LRR   = 3'd4;
    localparam logic [2:0] FRAME = 3'd5;

    localparam logic [3:0] S_AC  = 4'd0;
    localparam logic [3:0] S_LR2 = 4'd2;
    localparam logic [3:0] S_LR3 = 4'd3;
    localparam logic [3:0] S_LF1 = 4'd4;
    localparam logic [3:0] S_LF2 = 4'd5;
    localparam logic [3:0] S_OL1 = 4'd6;
    localparam logic [3:0] S_OL2 = 4'd7;

    logic       clk;
    logic       reset;
    logic [3:0] rx_state;
    logic       frame_valid;
    logic       frame_last;
    logic       frame_ready;
    logic       frame_abort;
    logic [2:0] tx_sel;
    logic       tx_active;

    fc_tx_scheduler #(
        .ENTRY_IDLES(ENTRY),
        .IFG_IDLES  (IFG),
        .SEQ_MIN    (SEQ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_state   (rx_state),
        .frame_valid(frame_valid),
        .frame_last (frame_last),
        .frame_ready(frame_ready),
        .frame_abort(frame_abort),
        .tx_sel     (tx_sel),
        .tx_active  (tx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: words sent since the last reset, plus event positions in that history.
    logic [2:0] hist[$];
    logic [3:0] m_st;
    logic       m_in;
    logic       m_abort;
    int         entry_idx;
    int         lf_idx;

    // Upstream frame source
    int fw       = 0;
    int flen     = 4;
    int flen_cfg = 4;

    logic [2:0] obs_sel;
    logic       obs_act;
    logic       obs_abort;
    logic       obs_rdy;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] tgt(input logic [3:0] s);
        case (s)
            4'd0: return IDLE;
            4'd1: return LR;
            4'd2: return LRR;
            4'd3: return IDLE;
            4'd4: return OLS;
            4'd5: return NOS;
            4'd6: return OLS;
            4'd7: return LR;
            4'd8: return NOS;
            default: return NOS;
        endcase
    endfunction

    function automatic int idles_since(input int idx, input int cap);
        int n = 0;
        for (int i = idx; i < hist.size() && n < cap; i++) begin
            if (hist[i] == IDLE) n++;
        end
        return n;
    endfunction

    task automatic mreset();
        hist.delete();
        m_st      = S_LF2;
        m_in      = 1'b0;
        m_abort   = 1'b0;
        entry_idx = 0;
        lf_idx    = -1;
        fw        = 0;
    endtask

    // One clock cycle: drive, check against the model, then advance the model across the edge.
    task automatic step(input logic [3:0] rx, input logic fv, input logic rst_n);
        logic       fl, act, gap_ok, rdy, ab, in_next;
        logic [2:0] t, last, prim, word;
        int         run;
        if (fw == 0) flen = flen_cfg;
        fl          = fv && (fw == flen - 1);
        rx_state    = rx;
        frame_valid = fv;
        frame_last  = fl;
        reset       = rst_n;
        #2;
        obs_sel   = tx_sel;
        obs_act   = tx_active;
        obs_abort = frame_abort;
        obs_rdy   = frame_ready;

        t = tgt(m_st);
        if (hist.size() == 0) begin
            last = NOS;
            run  = 0;
        end else begin
            last = hist[hist.size()-1];
            run  = 0;
            for (int i = hist.size() - 1; i >= 0 && hist[i] == last && run < SEQ; i--) run++;
        end
        prim = ((last inside {OLS, NOS, LR, LRR}) && t != IDLE && t != last && run < SEQ) ? last : t;
        act    = (m_st == S_AC) && (idles_since(entry_idx, ENTRY) >= ENTRY);
        gap_ok = (lf_idx < 0) || (idles_since(lf_idx, IFG) >= IFG);
        rdy    = fv && act && (m_in || gap_ok);
        word   = rdy ? FRAME : prim;

        chk("tx_sel", {5'd0, obs_sel}, {5'd0, word});
        chk("frame_ready", {7'd0, obs_rdy}, {7'd0, rdy});
        chk("frame_abort", {7'd0, obs_abort}, {7'd0, m_abort});
        chk("tx_active", {7'd0, obs_act}, {7'd0, act});

        if (!rst_n) begin
            mreset();
        end else begin
            in_next = rdy ? !fl : m_in;
            ab      = in_next && (rx != S_AC);
            if (rdy && fl) lf_idx = hist.size() + 1;
            if (ab) begin
                in_next = 1'b0;
                lf_idx  = -1;
            end
            hist.push_back(word);
            if (rx == S_AC && m_st != S_AC) entry_idx = hist.size();
            m_st    = rx;
            m_in    = in_next;
            m_abort = ab;
            if (rdy) fw = fl ? 0 : fw + 1;
            if (ab) fw = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [3:0] rx_r;
        int hold_len;

        reset       = 1'b0;
        rx_state    = S_LF2;
        frame_valid = 1'b0;
        frame_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mreset();

        // LF2 through and after reset: NOS, no frame acceptance
        repeat (3) step(S_LF2, 1'b1, 1'b0);
        repeat (12) step(S_LF2, 1'b1, 1'b1);
        chk("lf2_nos", {5'd0, obs_sel}, {5'd0, NOS});

        // OL2 -> LR2 -> LR3 -> AC, then the entry Idles
        repeat (20) step(S_OL2, 1'b0, 1'b1);
        repeat (20) step(S_LR2, 1'b0, 1'b1);
        repeat (20) step(S_LR3, 1'b0, 1'b1);
        step(S_AC, 1'b0, 1'b1);
        cnt = 0;
        repeat (19) begin
            step(S_AC, 1'b0, 1'b1);
            if (obs_sel == IDLE && !obs_act) cnt++;
        end
        chk("entry_idles", cnt[7:0], 8'd6);

        // Back-to-back 4-word frames
        flen_cfg = 4;
        cnt = 0;
        repeat (14) begin
            step(S_AC, 1'b1, 1'b1);
            if (obs_sel == FRAME) cnt++;
        end
        chk("frames_in_14", cnt[7:0], 8'd8);

        // Abort on word 2 of a 10-word frame
        flen_cfg = 10;
        guard = 0;
        while (fw != 0 && guard < 60) begin step(S_AC, 1'b1, 1'b1); guard++; end
        while (fw != 1 && guard < 60) begin step(S_AC, 1'b1, 1'b1); guard++; end
        chk("abort_setup_bound", {7'd0, guard < 60}, 8'd1);
        step(S_LF1, 1'b1, 1'b1);
        step(S_LF1, 1'b1, 1'b1);
        chk("abort_pulse", {7'd0, obs_abort}, 8'd1);
        chk("abort_ols", {5'd0, obs_sel}, {5'd0, OLS});
        repeat (10) step(S_LF1, 1'b1, 1'b1);
        repeat (20) step(S_AC, 1'b1, 1'b1);

        // OLS run must reach 8 words before NOS
        repeat (4) step(S_LR3, 1'b0, 1'b1);
        cnt = 0;
        repeat (4) begin step(S_OL1, 1'b0, 1'b1); if (obs_sel == OLS) cnt++; end
        repeat (15) begin step(S_LF2, 1'b0, 1'b1); if (obs_sel == OLS) cnt++; end
        chk("ols_run", cnt[7:0], 8'd8);
        chk("ols_then_nos", {5'd0, obs_sel}, {5'd0, NOS});

        // Reset pulse in the middle of a frame
        flen_cfg = 10;
        repeat (12) step(S_AC, 1'b1, 1'b1);
        repeat (12) step(S_AC, 1'b1, 1'b1);
        step(S_AC, 1'b1, 1'b0);
        step(S_AC, 1'b1, 1'b1);
        chk("rst_nos", {5'd0, obs_sel}, {5'd0, NOS});
        chk("rst_no_abort", {7'd0, obs_abort}, 8'd0);
        repeat (20) step(S_AC, 1'b1, 1'b1);

        // Randomized traffic and state changes
        cnt = 0;
        while (cnt < 2500) begin
            rx_r     = ($urandom_range(0, 1) == 0) ? S_AC : 4'($urandom_range(0, 15));
            hold_len = $urandom_range(1, 40);
            for (int k = 0; k < hold_len; k++) begin
                flen_cfg = $urandom_range(1, 8);
                step(rx_r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
                cnt++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_tx_scheduler.md
Name: fc_tx_scheduler

Overview:
- Transmit-side controller for one FC_Port, sitting between the receive state tracker (fc::state_t) and the transmit word mux.
- Every clock it decides which transmission word goes out: a primitive sequence (OLS/NOS/LR/LRR), Idle fill, or a frame word from the upstream frame source.
- Enforces the FC-FS-5 Table 22 transmit column, the minimum-Idle rule on entry to Active, the inter-frame fill gap, and frame abort on leaving Active.

Parameters:
- ENTRY_IDLES, 6, Idles transmitted after entering STATE_AC before the first frame word.
- IFG_IDLES, 6, minimum Idles between the last word of one frame and the first word of the next.
- SEQ_MIN, 8, minimum consecutive words of one primitive sequence before switching to another; a switch to Idle fill is exempt.

Ports:
- clk  in  1  word clock, one transmission word per cycle.
- reset  in  1  synchronous, active-low reset.
- rx_state  in  fc::state_t  current FC_Port state from the receive tracker.
- frame_valid  in  1  upstream frame word available.
- frame_last  in  1  qualifies the final word of a frame; valid only with frame_valid.
- frame_ready  out  1  frame word accepted this cycle; high only when frame_valid is high.
- frame_abort  out  1  one-cycle pulse: the in-progress frame was truncated.
- tx_sel  out  3  0=IDLE, 1=OLS, 2=NOS, 3=LR, 4=LRR, 5=FRAME.
- tx_active  out  1  scheduler is in frame-eligible Active mode.

Behaviour:
- Reset (reset==0 at a clk edge):
  - tx_sel=NOS (LF2 behaviour), frame_ready=0, frame_abort=0, tx_active=0.
  - entry counter=ENTRY_IDLES, gap counter=0, sequence counter=0, in_frame=0.
- Target word from rx_state, applied one cycle after rx_state changes (registered):
  - LF1→OLS, LF2→NOS, OL1→OLS, OL2→LR, OL3→NOS, LR1→LR, LR2→LRR, LR3→IDLE.
  - AC→IDLE or FRAME, per the Active rules below.
  - Any unlisted encoding→NOS.
- Primitive hold:
  - The sequence counter counts words of the current primitive, saturating at SEQ_MIN.
  - A different non-IDLE target is deferred until the counter reaches SEQ_MIN; the counter then clears on the switch.
  - A target of IDLE (LR3/AC) takes effect immediately.
- Active mode:
  - Entering AC (rx_state==AC while the previous registered state was not AC) loads the entry counter with ENTRY_IDLES.
  - Each IDLE word sent decrements the entry counter to 0.
  - tx_active=1 once the entry counter is 0 and rx_state==AC. Leaving AC clears tx_active the next cycle.
- Frame handshake:
  - frame_ready=frame_valid & tx_active & (gap counter==0 | in_frame). This is combinational from registered state and frame_valid.
  - tx_sel=FRAME on every cycle with frame_ready=1. Otherwise, while in AC, tx_sel=IDLE.
  - A ready word with frame_last=0 sets in_frame.
  - A ready word with frame_last=1 clears in_frame and loads the gap counter with IFG_IDLES.
  - The gap counter decrements on each IDLE word.
  - Upstream underrun (in_frame=1, frame_valid=0) sends IDLE and keeps in_frame; no abort is raised.
- Abort:
  - If rx_state leaves AC while in_frame=1, the next cycle gives frame_abort=1 for one cycle, frame_ready=0, in_frame=0, gap counter=0.
  - tx_sel takes the new target subject to the primitive hold (the previous word is counted as FRAME, so the switch is immediate).
- Simultaneous events:
  - An rx_state change and frame_last in the same cycle: the last word is accepted if frame_ready was high in that cycle, and no abort is raised.
  - Reset mid-frame: no abort pulse is raised; all state returns to reset values.
- frame_abort is never asserted together with frame_ready.

Test Plan:
- Hold rx_state=LF2 through and after reset release → tx_sel=2 (NOS) every cycle, frame_ready=0 even with frame_valid=1.
- Step rx_state OL2→LR2→LR3→AC with SEQ_MIN=8, each held 20 cycles → tx_sel sequence LR, LRR, IDLE with each change one cycle late. Then exactly 6 IDLE cycles after AC, after which tx_active=1.
- In AC/tx_active, offer two back-to-back 4-word frames with frame_valid held high → 4 FRAME, 6 IDLE, 4 FRAME. frame_ready is low during the 6 gap cycles.
- Mid-frame (word 2 of 10), drive rx_state=LF1 → next cycle frame_abort=1 for 1 cycle, tx_sel=1 (OLS), frame_ready=0. Return to AC → 6 entry Idles before any FRAME.
- Change rx_state OL1→LF2 after 3 OLS words → tx_sel stays OLS for 5 more cycles (8 total), then NOS.
- Assert reset=0 for one cycle during a frame in AC → the following cycle tx_sel=NOS, frame_ready=0, frame_abort=0, tx_active=0.
